// File: rtl/urv_cfg.sv
// Global configuration constants for the memory interface.
package urv_cfg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;
endpackage

// File: rtl/urv_typedef.sv
// Shared types: memory request/response payloads and bridge FSM states.
package urv_typedef;
  import urv_cfg::*;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_cmd_e;

  typedef struct packed {
    mem_cmd_e               cmd;
    logic [MEM_ADDR_W-1:0]  addr;
    logic [MEM_DATA_W-1:0]  data;
    logic [MEM_MASK_W-1:0]  mask;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0]  data;
    logic                   err;
  } mem_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_ERR   = 3'd4,
    ST_DRAIN = 3'd5
  } wb2mem_state_e;
endpackage

// File: rtl/wb2mem.sv
// Wishbone classic single-beat slave bridged onto the valid/ready memory interface.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// mem_req_valid/payload stay stable until accepted unless withdrawn by abort or timeout.
module wb2mem
  import urv_cfg::*;
  import urv_typedef::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [MEM_ADDR_W-1:0] wb_addr_i,
  input  logic [MEM_DATA_W-1:0] wb_data_i,
  input  logic [MEM_MASK_W-1:0] wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [MEM_DATA_W-1:0] wb_data_o,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output mem_req_t              mem_req,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  mem_resp_t             mem_resp,
  output wb2mem_state_e         dbg_state
);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  wb2mem_state_e         state, state_d;
  logic [TIMER_W-1:0]    timer;
  mem_req_t              req_q;
  logic [MEM_DATA_W-1:0] data_q;
  logic                  drain_q;
  logic                  set_drain;
  logic                  timeout;
  logic                  accept;

  assign accept  = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign timeout = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LIMIT);

  always_comb begin
    state_d   = state;
    set_drain = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_req_ready)  state_d = ST_WAIT;
        else if (!wb_cyc_i) state_d = ST_IDLE;
        else if (timeout)   state_d = ST_ERR;
      end
      ST_WAIT: begin
        // A response consumed after the master has gone needs no Wishbone pulse.
        if (mem_resp_valid) begin
          if (!wb_cyc_i)         state_d = ST_IDLE;
          else if (mem_resp.err) state_d = ST_ERR;
          else                   state_d = ST_ACK;
        end else if (!wb_cyc_i) begin
          state_d = ST_DRAIN;
        end else if (timeout) begin
          state_d   = ST_ERR;
          set_drain = 1'b1;
        end
      end
      ST_ACK:   state_d = ST_IDLE;
      ST_ERR:   state_d = drain_q ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (mem_resp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      timer   <= '0;
      req_q   <= '0;
      data_q  <= '0;
      drain_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        req_q.cmd  <= wb_we_i ? MEM_WRITE : MEM_READ;
        req_q.addr <= wb_addr_i;
        req_q.data <= wb_data_i;
        req_q.mask <= wb_sel_i;
        timer      <= '0;
      end else if ((state == ST_REQ || state == ST_WAIT) && timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end
      if (state == ST_WAIT && mem_resp_valid && !mem_resp.err && req_q.cmd == MEM_READ)
        data_q <= mem_resp.data;
      if (set_drain)
        drain_q <= 1'b1;
      else if (state == ST_ERR)
        drain_q <= 1'b0;
    end
  end

  assign mem_req_valid  = (state == ST_REQ);
  assign mem_req        = req_q;
  assign mem_resp_ready = (state == ST_WAIT) || (state == ST_DRAIN);
  assign wb_ack_o       = (state == ST_ACK);
  assign wb_err_o       = (state == ST_ERR);
  assign wb_data_o      = data_q;
  assign dbg_state      = state;
endmodule

// File: doc/wb2mem.md
# wb2mem

Wishbone classic-cycle slave that turns each single-beat Wishbone read or write into one request on the codebase's valid/ready memory interface (`mem_req_t` out, `mem_resp_t` back). It then returns exactly one `wb_ack_o` or `wb_err_o` to the Wishbone master. It lets external Wishbone masters (debug bridge, DMA, test harness) reach memory-interface slaves such as SRAM and peripherals. It is the responder-side counterpart of the CPU's memory-to-Wishbone master bridge. No burst support: CTI/BTE are not present.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles allowed from request launch to memory response before an error is returned; 0 disables the timeout.
- `MEM_ADDR_W`, `MEM_DATA_W`, `MEM_MASK_W`: taken from `urv_cfg`, not overridden.
- `clk` in 1: sole clock.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `wb_cyc_i` in 1: cycle valid.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_addr_i` in MEM_ADDR_W: byte address.
- `wb_data_i` in MEM_DATA_W: write data.
- `wb_sel_i` in MEM_MASK_W: byte selects.
- `wb_ack_o` out 1: single-cycle acknowledge pulse.
- `wb_err_o` out 1: single-cycle error pulse, mutually exclusive with ack.
- `wb_data_o` out MEM_DATA_W: read data, valid with ack.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req` out `mem_req_t`: request channel.
- `mem_resp_valid` in 1, `mem_resp_ready` out 1, `mem_resp` in `mem_resp_t`: response channel.

## Operation
- Every memory request produces exactly one response, for both reads and writes.
- The `mem_req` command is taken from `wb_we_i`. Address, data and mask are taken from `wb_addr_i`, `wb_data_i` and `wb_sel_i`, and are latched in registers.
- FSM states:
  - **IDLE**: on `wb_cyc_i & wb_stb_i`, latch the address, data, sel and command, clear the timer, go to REQ.
  - **REQ**: `mem_req_valid`=1 with the latched payload, held stable until `mem_req_ready`. On handshake go to WAIT.
    - If `wb_cyc_i` drops before the handshake, go to IDLE. No request is issued and no ack is given.
  - **WAIT**: `mem_resp_ready`=1. On `mem_resp_valid`, register the read data into `wb_data_o` and go to ACK. If the response error field is set, go to ERR instead.
    - If `wb_cyc_i` drops in WAIT, go to DRAIN.
  - **ACK** / **ERR**: pulse `wb_ack_o` or `wb_err_o` for one cycle, then go to IDLE. A strobe seen during ACK/ERR is not accepted; it is taken in the following IDLE cycle.
  - **DRAIN**: `mem_resp_ready`=1. Consume one response silently, then go to IDLE. There is no Wishbone output and no timeout in DRAIN.
- Timeout: the timer increments in REQ and WAIT and saturates.
  - When the timer equals `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES`≠0), go to ERR.
  - A timeout in REQ withdraws `mem_req_valid`, which is permitted only for timeout and abort.
  - A timeout in WAIT goes to ERR and then DRAIN rather than IDLE, so the late response is discarded.
- Simultaneous events:
  - A handshake and the timeout in the same cycle: the handshake wins.
  - A response and the timeout in the same cycle: the response wins.
- Asynchronous reset at any point: state goes to IDLE. Any outstanding memory transaction is abandoned; the memory side is reset together with this block.

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_data_o`=0, `mem_req_valid`=0, `mem_resp_ready`=0, `mem_req`=0.
- All outputs are driven from registers or the FSM state; there is no combinational path from Wishbone inputs to memory outputs.
- Minimum latency for a strobe sampled at edge N:
  - `mem_req_valid` is high during cycle N+1.
  - With ready during N+1 and `mem_resp_valid` during N+2, `wb_ack_o` is high during N+3.
  - Each cycle of ready or response stall adds one cycle.
- `wb_data_o` holds its value after the ack until the next read response. It is valid only while `wb_ack_o`=1.

## Structure
- Add the `wb2mem_state_e` enum (IDLE, REQ, WAIT, ACK, ERR, DRAIN) to `urv_typedef`.
- `mem_req_t` and `mem_resp_t` are used unchanged from `urv_typedef`.
- Single flat module, no sub-module. The timer is a `$clog2(TIMEOUT_CYCLES+1)`-bit counter kept inline.

## Test plan
- **Write**: write 0xDEADBEEF to 0x100 with sel=0xF, ready immediate, response one cycle later -> `mem_req` carries write/0x100/0xDEADBEEF/0xF; `wb_ack_o` is a 1-cycle pulse at N+3.
- **Read with stalls**: read 0x104, `mem_req_ready` low for 3 cycles, response data 0x12345678 with 2-cycle delay -> `mem_req` payload stable throughout the stall; ack at N+8 with `wb_data_o`=0x12345678.
- **Memory error**: response error bit set on a read -> `wb_err_o` pulses once and `wb_ack_o` stays 0.
- **Timeout**: `TIMEOUT_CYCLES`=8, memory accepts but never responds -> `wb_err_o` pulse. A later response is absorbed in DRAIN with no Wishbone pulse, and the next transaction completes normally.
- **Abort**: `wb_cyc_i` drops while REQ is not yet accepted -> no memory handshake and no ack/err. A second case drops `wb_cyc_i` in WAIT -> the response is drained silently.
- **Reset**: `rstn` asserted in WAIT -> all outputs are 0 immediately. After release, a back-to-back read then write to 0x200 acks correctly.
